// File: rtl/div_sequencer_if.sv
// Request/response handshake bundle between a client and div_sequencer.
// The master modport is the client side; the slave modport is the sequencer side.
interface div_sequencer_if #(
  parameter int PARALLELISM = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [PARALLELISM-1:0] req_dividend;
  logic [PARALLELISM-1:0] req_divisor;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [PARALLELISM-1:0] resp_result;
  logic                   resp_err;

  modport master (
    output req_valid, req_op, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/div_sequencer.sv
// RISC-V DIV/DIVU/REM/REMU front-end for an unsigned DivisorUnit: handles the
// corner cases locally and applies sign fix-up. Define DIV_TIMEOUT_EN for a busy watchdog.
module div_sequencer #(
  parameter int PARALLELISM    = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  div_sequencer_if.slave         bus,
  output logic                   div_valid,
  output logic                   div_usigned,
  output logic [PARALLELISM-1:0] div_dividend,
  output logic [PARALLELISM-1:0] div_divisor,
  input  logic [PARALLELISM-1:0] div_quotient,
  input  logic [PARALLELISM-1:0] div_reminder,
  input  logic                   div_res_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [PARALLELISM-1:0] ALL_ONES = '1;
  localparam logic [PARALLELISM-1:0] MOST_NEG = {1'b1, {(PARALLELISM-1){1'b0}}};

  if (PARALLELISM < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("div_sequencer: PARALLELISM must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]             state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   div_valid_q, div_valid_d;
  logic [PARALLELISM-1:0] div_dividend_q, div_dividend_d;
  logic [PARALLELISM-1:0] div_divisor_q, div_divisor_d;
  logic [PARALLELISM-1:0] quot_q, quot_d;
  logic [PARALLELISM-1:0] rem_q, rem_d;
  logic [PARALLELISM-1:0] resp_result_q, resp_result_d;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          resp_err_q, resp_err_d;
`endif

  logic                   req_signed;
  logic                   sa, sb;
  logic                   div_by_zero;
  logic                   sgn_overflow;
  logic [PARALLELISM-1:0] fix_sel;
  logic                   fix_neg;

  // Request decode: signed ops have op[0]==0; flags are zero for unsigned ops.
  assign req_signed   = ~bus.req_op[0];
  assign sa           = req_signed & bus.req_dividend[PARALLELISM-1];
  assign sb           = req_signed & bus.req_divisor[PARALLELISM-1];
  assign div_by_zero  = (bus.req_divisor == '0);
  assign sgn_overflow = req_signed && (bus.req_dividend == MOST_NEG) && (bus.req_divisor == ALL_ONES);

  assign fix_sel = op_q[1] ? rem_q : quot_q;
  assign fix_neg = op_q[1] ? r_neg_q : q_neg_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    q_neg_d        = q_neg_q;
    r_neg_d        = r_neg_q;
    div_valid_d    = div_valid_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    quot_d         = quot_q;
    rem_d          = rem_q;
    resp_result_d  = resp_result_q;
`ifdef DIV_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    resp_err_d     = resp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          q_neg_d = sa ^ sb;
          r_neg_d = sa;
          if (div_by_zero) begin
            resp_result_d = bus.req_op[1] ? bus.req_dividend : ALL_ONES;
            state_d       = ST_RESP;
          end else if (sgn_overflow) begin
            resp_result_d = bus.req_op[1] ? '0 : bus.req_dividend;
            state_d       = ST_RESP;
          end else begin
            // Most-negative input negates to itself, which reads as 2^(P-1) unsigned.
            div_dividend_d = sa ? (~bus.req_dividend + 1'b1) : bus.req_dividend;
            div_divisor_d  = sb ? (~bus.req_divisor + 1'b1) : bus.req_divisor;
            div_valid_d    = 1'b1;
            state_d        = ST_BUSY;
`ifdef DIV_TIMEOUT_EN
            tmo_cnt_d      = '0;
`endif
          end
        end
      end

      ST_BUSY: begin
        if (div_res_ready) begin
          quot_d      = div_quotient;
          rem_d       = div_reminder;
          div_valid_d = 1'b0;
          state_d     = ST_FIX;
        end
`ifdef DIV_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          div_valid_d   = 1'b0;
          resp_result_d = '0;
          resp_err_d    = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_FIX: begin
        resp_result_d = fix_neg ? (~fix_sel + 1'b1) : fix_sel;
        state_d       = ST_RESP;
      end

      default: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
`ifdef DIV_TIMEOUT_EN
          resp_err_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= 2'b00;
      q_neg_q        <= 1'b0;
      r_neg_q        <= 1'b0;
      div_valid_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      quot_q         <= '0;
      rem_q          <= '0;
      resp_result_q  <= '0;
`ifdef DIV_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      resp_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      q_neg_q        <= q_neg_d;
      r_neg_q        <= r_neg_d;
      div_valid_q    <= div_valid_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      quot_q         <= quot_d;
      rem_q          <= rem_d;
      resp_result_q  <= resp_result_d;
`ifdef DIV_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      resp_err_q     <= resp_err_d;
`endif
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.resp_valid  = (state_q == ST_RESP);
  assign bus.resp_result = resp_result_q;
`ifdef DIV_TIMEOUT_EN
  assign bus.resp_err    = resp_err_q;
`else
  assign bus.resp_err    = 1'b0;
`endif

  assign div_valid    = div_valid_q;
  assign div_usigned  = 1'b1;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural DivisorUnit model.
// Define DIV_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_div_sequencer;

  localparam int P = 32;
`ifdef DIV_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] result;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_valid;
  logic        div_usigned;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_reminder = '0;
  logic        div_res_ready = 1'b0;

  div_sequencer_if #(.PARALLELISM(P)) bus ();

  div_sequencer #(.PARALLELISM(P), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .div_valid    (div_valid),
    .div_usigned  (div_usigned),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_reminder (div_reminder),
    .div_res_ready(div_res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t        sb_q[$];
  logic [63:0] mag_q[$];
  int  rr_mode    = 0;
  bit  div_hold   = 1'b0;
  bit  stray_req  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout/unexpected expected=event at %0t", name, $time);
  endtask

  // Reference: RISC-V M-extension divide semantics in plain arithmetic.
  function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] q, r;
    e.err = 1'b0;
    if (b == 0) begin
      q = ONES;
      r = a;
    end else if (!op[0] && a == MIN_INT && b == ONES) begin
      q = a;
      r = 0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    e.result = op[1] ? r : q;
    return e;
  endfunction

  function automatic logic [31:0] magOf(input logic [31:0] x, input bit sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit expect_tmo);
    int n = 0;
    bit special;
    exp_t e;
    @(negedge clk);
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      reportFail("req_ready_wait");
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    @(posedge clk);
    special = (b == 0) || (!op[0] && a == MIN_INT && b == ONES);
    e = refModel(op, a, b);
    if (expect_tmo) begin
      e.result = 0;
      e.err    = 1'b1;
    end
    sb_q.push_back(e);
    if (!special && !expect_tmo)
      mag_q.push_back({magOf(a, !op[0]), magOf(b, !op[0])});
    #1;
    bus.req_valid = 1'b0;
    checkOutput("req_ready_after_accept", {31'b0, bus.req_ready}, 32'd0);
    if (special) begin
      checkOutput("special_resp_latency", {31'b0, bus.resp_valid}, 32'd1);
      checkOutput("special_no_div_valid", {31'b0, div_valid}, 32'd0);
    end else begin
      checkOutput("issue_div_valid", {31'b0, div_valid}, 32'd1);
      checkOutput("issue_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb_q.size() != 0 || mag_q.size() != 0 || !bus.req_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) reportFail("drain_timeout");
  endtask

  function automatic logic [31:0] genOperand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = $urandom_range(0, 300);
      1: v = 32'd0 - $urandom_range(1, 300);
      2: v = MIN_INT;
      3: v = ONES;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // resp_ready driver: random backpressure, forced low, or forced high.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: bus.resp_ready = ($urandom_range(0, 3) != 0);
        1: bus.resp_ready = 1'b0;
        default: bus.resp_ready = 1'b1;
      endcase
    end
  end

  // DivisorUnit model: checks issued magnitudes, answers after a random delay.
  initial begin
    logic [63:0] m;
    logic [31:0] dd, ds;
    int dly;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        div_res_ready = 1'b1;
        @(posedge clk);
        #1;
        div_res_ready = 1'b0;
        stray_req = 1'b0;
      end else if (div_valid && !div_hold && !rst) begin
        checkOutput("div_usigned", {31'b0, div_usigned}, 32'd1);
        if (mag_q.size() == 0) begin
          reportFail("unexpected_div_issue");
          m = {div_dividend, div_divisor};
        end else begin
          m = mag_q.pop_front();
        end
        checkOutput("div_dividend_mag", div_dividend, m[63:32]);
        checkOutput("div_divisor_mag", div_divisor, m[31:0]);
        dd = m[63:32];
        ds = m[31:0];
        dly = $urandom_range(0, 4);
        repeat (dly) begin
          div_quotient = $urandom;
          div_reminder = $urandom;
          @(posedge clk);
          #1;
          checkOutput("div_valid_held", {31'b0, div_valid}, 32'd1);
        end
        div_quotient  = (ds == 0) ? ONES : dd / ds;
        div_reminder  = (ds == 0) ? dd : dd % ds;
        div_res_ready = 1'b1;
        @(posedge clk);
        #1;
        div_res_ready = 1'b0;
        div_quotient  = $urandom;
        div_reminder  = $urandom;
        checkOutput("div_valid_dropped", {31'b0, div_valid}, 32'd0);
        checkOutput("fix_cycle_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("normal_resp_latency", {31'b0, bus.resp_valid}, 32'd1);
      end
    end
  end

  // Monitor: compares each accepted response against the scoreboard head.
  initial begin
    bit prev_hold = 1'b0;
    logic [31:0] prev_res = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else if (bus.resp_valid) begin
        if (prev_hold) checkOutput("resp_stable", bus.resp_result, prev_res);
        if (bus.resp_ready) begin
          if (sb_q.size() == 0) begin
            reportFail("unexpected_resp");
          end else begin
            e = sb_q.pop_front();
            checkOutput("resp_result", bus.resp_result, e.result);
            checkOutput("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_res  = bus.resp_result;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    reportFail("global_watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [31:0] held;
    int n;
    logic [1:0] op;
    logic [31:0] a, b;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("rst_resp_result", bus.resp_result, 32'd0);
    checkOutput("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    checkOutput("rst_div_valid", {31'b0, div_valid}, 32'd0);
    checkOutput("rst_div_dividend", div_dividend, 32'd0);
    checkOutput("rst_div_divisor", div_divisor, 32'd0);
    rst = 1'b0;

    $display("[TB] directed operand cases");
    applyStimulus(OP_DIVU, 32'h75, 32'hA, 1'b0);
    applyStimulus(OP_REMU, 32'h75, 32'hA, 1'b0);
    applyStimulus(OP_DIV,  32'hFFFF_FF8B, 32'hA, 1'b0);
    applyStimulus(OP_REM,  32'hFFFF_FF8B, 32'hA, 1'b0);
    applyStimulus(OP_REM,  32'h75, 32'hFFFF_FFF6, 1'b0);
    applyStimulus(OP_DIVU, 32'h75, 32'h0, 1'b0);
    applyStimulus(OP_REM,  32'h75, 32'h0, 1'b0);
    applyStimulus(OP_DIV,  MIN_INT, ONES, 1'b0);
    applyStimulus(OP_REM,  MIN_INT, ONES, 1'b0);
    applyStimulus(OP_DIVU, MIN_INT, ONES, 1'b0);
    applyStimulus(OP_DIV,  MIN_INT, 32'd2, 1'b0);
    applyStimulus(OP_REM,  32'hFFFF_FF8B, MIN_INT, 1'b0);
    waitDrain();

    $display("[TB] backpressure");
    rr_mode = 1;
    applyStimulus(OP_DIVU, 32'h75, 32'hA, 1'b0);
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) reportFail("bp_resp_wait");
    held = bus.resp_result;
    checkOutput("bp_result_value", held, 32'h0000_000B);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      checkOutput("bp_result_stable", bus.resp_result, held);
      checkOutput("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    rr_mode = 2;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("bp_release_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("bp_release_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    rr_mode = 0;
    waitDrain();

    $display("[TB] reset while busy");
    div_hold = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = OP_DIVU;
    bus.req_dividend = 32'd1000;
    bus.req_divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_div_valid", {31'b0, div_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_div_valid", {31'b0, div_valid}, 32'd0);
    checkOutput("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("midrst_div_dividend", div_dividend, 32'd0);
    stray_req = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("stray_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
    div_hold = 1'b0;

`ifdef DIV_TIMEOUT_EN
    $display("[TB] divider timeout");
    div_hold = 1'b1;
    applyStimulus(OP_DIV, 32'd50, 32'd3, 1'b1);
    waitDrain();
    checkOutput("tmo_div_valid", {31'b0, div_valid}, 32'd0);
    checkOutput("tmo_err_cleared", {31'b0, bus.resp_err}, 32'd0);
    div_hold = 1'b0;
`endif

    $display("[TB] randomized requests");
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = genOperand();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : genOperand();
      applyStimulus(op, a, b, 1'b0);
    end
    waitDrain();

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Request/response front-end for DivisorUnit: accepts RISC-V style DIV/DIVU/REM/REMU requests and returns the selected result.
- Resolves divide-by-zero and signed overflow locally, without issuing to the divider.
- For signed ops, converts operands to magnitudes, issues an unsigned division to DivisorUnit, waits for its res_ready, then applies sign fix-up.
- Sits directly upstream and downstream of DivisorUnit: drives its valid/usigned/dividend/divisor, consumes its quotient/reminder/res_ready.

Parameters:
PARALLELISM, 32, operand/result width; must equal DivisorUnit parallelism
TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with DIV_TIMEOUT_EN

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_dividend  in  PARALLELISM  dividend (two's complement when signed)
req_divisor  in  PARALLELISM  divisor
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_result  out  PARALLELISM  quotient or remainder per op
resp_err  out  1  divider timeout; constant 0 without DIV_TIMEOUT_EN
div_valid  out  1  to DivisorUnit valid
div_usigned  out  1  to DivisorUnit usigned; constant 1
div_dividend  out  PARALLELISM  magnitude of dividend
div_divisor  out  PARALLELISM  magnitude of divisor
div_quotient  in  PARALLELISM  from DivisorUnit quotient
div_reminder  in  PARALLELISM  from DivisorUnit reminder
div_res_ready  in  1  from DivisorUnit res_ready; level, sampled

Behaviour:
- Reset values, also applied on any rst cycle mid-operation: state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, div_valid=0, div_dividend=0, div_divisor=0.
- On reset, any in-flight divider result is abandoned.
- States are IDLE, BUSY, FIX, RESP.
- IDLE:
  - req_ready=1. A request is accepted on an edge where req_valid=1. The op and operands are latched.
  - Signed op: sa, sb are the operand MSBs. q_neg = sa^sb; r_neg = sa. Both are 0 for unsigned ops.
  - Divisor == 0 (any op): quotient = all ones, remainder = dividend. Go to RESP with the selected value.
  - Signed op with dividend == 1<<(PARALLELISM-1) and divisor == all ones: quotient = dividend, remainder = 0. Go to RESP.
  - Otherwise: div_dividend/div_divisor = magnitude (negate if signed and MSB set; most-negative value maps to 2^(P-1) unsigned). Go to BUSY.
- BUSY:
  - div_valid=1, held until div_res_ready is sampled high.
  - On that edge, latch div_quotient/div_reminder, drop div_valid, go to FIX.
  - div_res_ready seen in any state other than BUSY is ignored.
- FIX:
  - Selects quotient (DIV/DIVU) or remainder (REM/REMU).
  - Negates it (two's complement) if the matching neg flag is set.
  - Registers it into resp_result and goes to RESP.
- RESP:
  - resp_valid=1; resp_result and resp_err are held stable while resp_ready=0.
  - On an edge with resp_valid & resp_ready, go to IDLE. req_ready is high the next cycle; no same-cycle back-to-back acceptance.
- req_ready=0 in BUSY, FIX and RESP.
- Latency, normal: resp_valid rises 2 cycles after the cycle div_res_ready is high.
- Latency, special case: resp_valid rises the cycle after acceptance; div_valid is never asserted.

Optional Feature:
DIV_TIMEOUT_EN:
- Defined: a counter clears on entering BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES without div_res_ready, div_valid drops and the block goes to RESP with resp_result=0 and resp_err=1. resp_err clears when the response is accepted.
- Undefined: no counter, resp_err tied 0, and BUSY waits indefinitely.

Test Plan:
1. DIVU 0x75/0xA -> div_dividend=0x75, div_divisor=0xA, div_usigned=1; resp_result=0x0000000B. REMU same operands -> 0x00000007.
2. DIV 0xFFFFFF8B/0xA -> divider sees 0x75/0xA; resp_result=0xFFFFFFF5. REM same operands -> 0xFFFFFFF9. REM 0x75/0xFFFFFFF6 -> 0x00000007.
3. DIVU 0x75/0 -> resp_result=0xFFFFFFFF. REM 0x75/0 -> 0x00000075. div_valid stays 0 and resp_valid is high the cycle after acceptance.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0x00000000; both without divider issue.
5. Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid=1, resp_result stable, req_ready=0. Raise resp_ready -> req_ready=1 next cycle.
6. rst in BUSY -> next cycle IDLE with div_valid=0 and resp_valid=0. A later div_res_ready pulse produces no response. With DIV_TIMEOUT_EN and TIMEOUT_CYCLES=8, withholding div_res_ready -> resp_valid with resp_err=1 and resp_result=0.
